// File: rtl/lane_lamp_driver.sv
// Lane lamp driver: turns WWSSEENN lane words into per-direction R/Y/G lamp drives.
// Every green change passes through yellow and an all-red clearance; illegal words latch a flashing-red fault.
module lane_lamp_driver #(
    parameter int YELLOW_CYCLES = 3,
    parameter int CLEAR_CYCLES  = 2,
    parameter int FLASH_PERIOD  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  laneCmd,
    input  logic        cmdValid,
    output logic [11:0] lamps,
    output logic [7:0]  currentLane,
    output logic        busy,
    output logic        fault
);

    // state     | meaning
    // ALL_RED   | idle, every direction red
    // GREEN_NS  | north/south green
    // GREEN_EW  | east/west green
    // YELLOW_NS | north/south yellow before clearance
    // YELLOW_EW | east/west yellow before clearance
    // CLEAR     | all-red clearance, then go to target
    // FAULT     | illegal word seen, flashing red until reset
    localparam logic [2:0] ST_ALL_RED   = 3'd0;
    localparam logic [2:0] ST_GREEN_NS  = 3'd1;
    localparam logic [2:0] ST_GREEN_EW  = 3'd2;
    localparam logic [2:0] ST_YELLOW_NS = 3'd3;
    localparam logic [2:0] ST_YELLOW_EW = 3'd4;
    localparam logic [2:0] ST_CLEAR     = 3'd5;
    localparam logic [2:0] ST_FAULT     = 3'd6;

    localparam logic [1:0] T_NONE = 2'd0;
    localparam logic [1:0] T_NS   = 2'd1;
    localparam logic [1:0] T_EW   = 2'd2;

    localparam logic [7:0] WORD_EW   = 8'b11001100;
    localparam logic [7:0] WORD_NS   = 8'b00110011;
    localparam logic [7:0] WORD_STOP = 8'b00000000;

    localparam logic [11:0] LAMPS_RED  = 12'b100100100100;
    localparam logic [11:0] LAMPS_G_NS = 12'b100001100001;
    localparam logic [11:0] LAMPS_G_EW = 12'b001100001100;
    localparam logic [11:0] LAMPS_Y_NS = 12'b100010100010;
    localparam logic [11:0] LAMPS_Y_EW = 12'b010100010100;

    localparam logic [7:0] YEL_LOAD   = 8'(YELLOW_CYCLES - 1);
    localparam logic [7:0] CLR_LOAD   = 8'(CLEAR_CYCLES - 1);
    localparam logic [7:0] FLASH_LOAD = 8'(FLASH_PERIOD - 1);

    logic [2:0]  state, state_d;
    logic [7:0]  cnt, cnt_d;
    logic [1:0]  target, target_d;
    logic        flash, flash_d;
    logic        cmd_legal;
    logic [1:0]  cmd_tgt;
    logic [11:0] lamps_d;
    logic [7:0]  lane_d;
    logic        busy_d, fault_d;

    always_comb begin
        cmd_legal = (laneCmd == WORD_EW) || (laneCmd == WORD_NS) || (laneCmd == WORD_STOP);
        cmd_tgt   = (laneCmd == WORD_EW) ? T_EW : (laneCmd == WORD_NS) ? T_NS : T_NONE;
    end

    // Phase timers are down-counters loaded with length-1 and advanced on terminal count zero.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        target_d = target;
        flash_d  = flash;
        if (state != ST_FAULT && cmdValid && !cmd_legal) begin
            state_d = ST_FAULT;
            cnt_d   = FLASH_LOAD;
            flash_d = 1'b0;
        end else begin
            case (state)
                ST_ALL_RED: begin
                    if (cmdValid && cmd_tgt == T_EW) state_d = ST_GREEN_EW;
                    else if (cmdValid && cmd_tgt == T_NS) state_d = ST_GREEN_NS;
                end
                ST_GREEN_NS: begin
                    if (cmdValid && cmd_tgt != T_NS) begin
                        target_d = cmd_tgt;
                        state_d  = ST_YELLOW_NS;
                        cnt_d    = YEL_LOAD;
                    end
                end
                ST_GREEN_EW: begin
                    if (cmdValid && cmd_tgt != T_EW) begin
                        target_d = cmd_tgt;
                        state_d  = ST_YELLOW_EW;
                        cnt_d    = YEL_LOAD;
                    end
                end
                ST_YELLOW_NS, ST_YELLOW_EW: begin
                    if (cmdValid) target_d = cmd_tgt;
                    if (cnt == 8'd0) begin
                        state_d = ST_CLEAR;
                        cnt_d   = CLR_LOAD;
                    end else begin
                        cnt_d = cnt - 8'd1;
                    end
                end
                ST_CLEAR: begin
                    // A command in the final clearance cycle steers this very transition.
                    if (cmdValid) target_d = cmd_tgt;
                    if (cnt == 8'd0) begin
                        cnt_d = 8'd0;
                        case (target_d)
                            T_NS:    state_d = ST_GREEN_NS;
                            T_EW:    state_d = ST_GREEN_EW;
                            default: state_d = ST_ALL_RED;
                        endcase
                    end else begin
                        cnt_d = cnt - 8'd1;
                    end
                end
                ST_FAULT: begin
                    if (cnt == 8'd0) begin
                        flash_d = ~flash;
                        cnt_d   = FLASH_LOAD;
                    end else begin
                        cnt_d = cnt - 8'd1;
                    end
                end
                default: state_d = ST_ALL_RED;
            endcase
        end
    end

    // Outputs are decoded from the next state so the registered lamps line up with the state.
    always_comb begin
        lamps_d = LAMPS_RED;
        lane_d  = 8'd0;
        busy_d  = 1'b0;
        fault_d = 1'b0;
        case (state_d)
            ST_GREEN_NS: begin
                lamps_d = LAMPS_G_NS;
                lane_d  = WORD_NS;
            end
            ST_GREEN_EW: begin
                lamps_d = LAMPS_G_EW;
                lane_d  = WORD_EW;
            end
            ST_YELLOW_NS: begin
                lamps_d = LAMPS_Y_NS;
                busy_d  = 1'b1;
            end
            ST_YELLOW_EW: begin
                lamps_d = LAMPS_Y_EW;
                busy_d  = 1'b1;
            end
            ST_CLEAR: busy_d = 1'b1;
            ST_FAULT: begin
                lamps_d = flash_d ? 12'd0 : LAMPS_RED;
                fault_d = 1'b1;
            end
            default: lamps_d = LAMPS_RED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_ALL_RED;
            cnt         <= 8'd0;
            target      <= T_NONE;
            flash       <= 1'b0;
            lamps       <= LAMPS_RED;
            currentLane <= 8'd0;
            busy        <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            target      <= target_d;
            flash       <= flash_d;
            lamps       <= lamps_d;
            currentLane <= lane_d;
            busy        <= busy_d;
            fault       <= fault_d;
        end
    end

endmodule

// File: tb/tb_lane_lamp_driver.sv
// Directed bench for lane_lamp_driver: sequencing, latest-wins target, fault flash and async reset.
module tb_lane_lamp_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  laneCmd;
    logic        cmdValid;
    logic [11:0] lamps;
    logic [7:0]  currentLane;
    logic        busy;
    logic        fault;

    int total = 0;
    int bad   = 0;

    localparam logic [11:0] RED  = 12'b100100100100;
    localparam logic [11:0] GNS  = 12'b100001100001;
    localparam logic [11:0] GEW  = 12'b001100001100;
    localparam logic [11:0] YNS  = 12'b100010100010;
    localparam logic [11:0] YEW  = 12'b010100010100;
    localparam logic [7:0]  W_EW = 8'b11001100;
    localparam logic [7:0]  W_NS = 8'b00110011;
    localparam logic [7:0]  W_ST = 8'b00000000;

    lane_lamp_driver #(.YELLOW_CYCLES(3), .CLEAR_CYCLES(2), .FLASH_PERIOD(4)) dut (
        .clk(clk), .rst(rst), .laneCmd(laneCmd), .cmdValid(cmdValid),
        .lamps(lamps), .currentLane(currentLane), .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c);
        laneCmd  = c;
        cmdValid = 1'b1;
        tick();
        cmdValid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [11:0] l, input logic [7:0] cl,
                       input logic b, input logic f);
        total++;
        assert (lamps === l) else begin
            bad++;
            $error("FAIL %s lamps got %b want %b", tag, lamps, l);
        end
        total++;
        assert (currentLane === cl) else begin
            bad++;
            $error("FAIL %s currentLane got %b want %b", tag, currentLane, cl);
        end
        total++;
        assert ({busy, fault} === {b, f}) else begin
            bad++;
            $error("FAIL %s busy/fault got %b%b want %b%b", tag, busy, fault, b, f);
        end
    endtask

    initial begin
        rst = 1'b1; laneCmd = 8'd0; cmdValid = 1'b0;
        #12;
        chk("reset", RED, 8'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk("idle", RED, 8'd0, 1'b0, 1'b0);
        send(W_ST);
        chk("allred_stop", RED, 8'd0, 1'b0, 1'b0);

        send(W_EW);
        chk("green_ew", GEW, W_EW, 1'b0, 1'b0);
        send(W_EW);
        chk("green_ew_noop", GEW, W_EW, 1'b0, 1'b0);

        send(W_NS);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("yellow_ew%0d", i), YEW, 8'd0, 1'b1, 1'b0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("clear_a%0d", i), RED, 8'd0, 1'b1, 1'b0);
            tick();
        end
        chk("green_ns", GNS, W_NS, 1'b0, 1'b0);

        // EW requested, then all-stop during yellow cycle 2 overrides it
        send(W_EW);
        chk("yellow_ns1", YNS, 8'd0, 1'b1, 1'b0);
        tick();
        chk("yellow_ns2", YNS, 8'd0, 1'b1, 1'b0);
        send(W_ST);
        chk("yellow_ns3", YNS, 8'd0, 1'b1, 1'b0);
        tick();
        chk("clear_b0", RED, 8'd0, 1'b1, 1'b0);
        tick();
        chk("clear_b1", RED, 8'd0, 1'b1, 1'b0);
        tick();
        chk("allred_end", RED, 8'd0, 1'b0, 1'b0);

        // NS re-granted via a command in the last clearance cycle
        send(W_NS);
        chk("green_ns2", GNS, W_NS, 1'b0, 1'b0);
        send(W_ST);
        tick(); tick(); tick();
        chk("clear_c0", RED, 8'd0, 1'b1, 1'b0);
        tick();
        chk("clear_c1", RED, 8'd0, 1'b1, 1'b0);
        send(W_NS);
        chk("regrant_ns", GNS, W_NS, 1'b0, 1'b0);

        // conflicting word -> flashing fault, later commands ignored
        send(8'b11110000);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("flash%0d", i), ((i / 4) % 2 == 1) ? 12'd0 : RED, 8'd0, 1'b0, 1'b1);
            if (i == 5) send(W_EW);
            else tick();
        end

        rst = 1'b1;
        #2;
        chk("rst_from_fault", RED, 8'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        send(8'b01001100);
        chk("malformed0", RED, 8'd0, 1'b0, 1'b1);
        tick(); tick(); tick(); tick();
        chk("malformed_dark", 12'd0, 8'd0, 1'b0, 1'b1);

        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
        send(W_EW);
        send(W_NS);
        tick(); tick(); tick();
        chk("pre_rst_clear", RED, 8'd0, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", RED, 8'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        send(W_NS);
        chk("after_rst_ns", GNS, W_NS, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
